// File: rtl/exe_divider_pkg.sv
// -----------------------------------------------------------------------------
// exe_divider_pkg
// Shared constants and types for the execute-stage divider:
//   DATALENGTH / ZEROWORD  - datapath width and all-zero word
//   div_op_e               - isDivE encodings (DIV_NONE, DIV_SIGNED, DIV_UNSIGNED)
//   div_state_e            - divider FSM state encodings
//   COUNT_W / LAST_COUNT   - iteration counter width and final step index
//   neg_if()               - conditional two's-complement negation
// -----------------------------------------------------------------------------
package exe_divider_pkg;

    localparam int                    DATALENGTH = 32;
    localparam logic [DATALENGTH-1:0] ZEROWORD   = '0;

    localparam int                 COUNT_W    = $clog2(DATALENGTH);
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(DATALENGTH - 1);

    // 2'b11 is not a valid request and is handled exactly like DIV_NONE.
    typedef enum logic [1:0] {
        DIV_NONE     = 2'b00,
        DIV_SIGNED   = 2'b01,
        DIV_UNSIGNED = 2'b10,
        DIV_RSVD     = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    // Two's-complement negation when 'negate' is set; also serves as |x|
    // when 'negate' is the sign bit of x.
    function automatic logic [DATALENGTH-1:0] neg_if(
        input logic [DATALENGTH-1:0] value,
        input logic                  negate
    );
        return negate ? (ZEROWORD - value) : value;
    endfunction

endpackage

// File: rtl/exe_divider.sv
// -----------------------------------------------------------------------------
// exe_divider
// Multi-cycle 32-bit restoring divider for the execute stage (DIV / DIVU).
// One request is captured in IDLE, 32 shift-subtract steps run in BUSY, and
// the sign-corrected result is registered on entry to DONE, where it is held
// while the pipeline is stalled elsewhere.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   isDivE     in   2'b01 signed DIV, 2'b10 unsigned DIVU, otherwise none
//   SrcAE      in   dividend (rs)
//   SrcBE      in   divisor (rt)
//   FlushE     in   cancels an in-flight division / blocks a start
//   StallIn    in   pipeline held by another source; hold DONE
//   StallDivE  out  stall request for F/D/E while dividing
//   DivValidE  out  HiDivE/LoDivE carry a valid result this cycle
//   HiDivE     out  remainder
//   LoDivE     out  quotient
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, a zero divisor skips BUSY and goes from
//                     IDLE straight to DONE with the divide-by-zero result.
// -----------------------------------------------------------------------------
module exe_divider
    import exe_divider_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            isDivE,
    input  logic [DATALENGTH-1:0] SrcAE,
    input  logic [DATALENGTH-1:0] SrcBE,
    input  logic                  FlushE,
    input  logic                  StallIn,
    output logic                  StallDivE,
    output logic                  DivValidE,
    output logic [DATALENGTH-1:0] HiDivE,
    output logic [DATALENGTH-1:0] LoDivE
);

    div_state_e              r_state;
    div_state_e              w_state_next;
    logic [COUNT_W-1:0]      r_count;
    logic [DATALENGTH-1:0]   r_rem;       // partial remainder
    logic [DATALENGTH-1:0]   r_quo;       // dividend bits shift out, quotient bits shift in
    logic [DATALENGTH-1:0]   r_div;       // divisor magnitude
    logic                    r_sign_a;    // dividend negative (signed op only)
    logic                    r_sign_b;    // divisor negative (signed op only)
    logic                    r_div_zero;
    logic [DATALENGTH-1:0]   r_hi;
    logic [DATALENGTH-1:0]   r_lo;

    div_op_e                 w_op;
    logic                    w_req;
    logic                    w_is_signed;
    logic                    w_zero_div;
    logic                    w_start;
    logic                    w_finish;
    logic                    w_stall;
    logic                    w_valid;

    logic [DATALENGTH:0]     w_shift;
    logic [DATALENGTH:0]     w_diff;
    logic                    w_fits;
    logic [DATALENGTH-1:0]   w_rem_step;
    logic [DATALENGTH-1:0]   w_quo_step;
    logic [DATALENGTH-1:0]   w_hi_fixed;
    logic [DATALENGTH-1:0]   w_lo_fixed;

    assign w_op        = div_op_e'(isDivE);
    assign w_is_signed = (w_op == DIV_SIGNED);
    assign w_req       = (w_op == DIV_SIGNED) || (w_op == DIV_UNSIGNED);
    assign w_zero_div  = (SrcBE == ZEROWORD);

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The 33-bit shift cannot overflow
    // because the remainder is always below the divisor.
    assign w_shift    = {r_rem, r_quo[DATALENGTH-1]};
    assign w_diff     = w_shift - {1'b0, r_div};
    assign w_fits     = ~w_diff[DATALENGTH];
    assign w_rem_step = w_fits ? w_diff[DATALENGTH-1:0] : w_shift[DATALENGTH-1:0];
    assign w_quo_step = {r_quo[DATALENGTH-2:0], w_fits};

    // Sign fix-up on the final step's values. A zero divisor yields an
    // all-ones magnitude quotient, which the sign rule would corrupt, so the
    // quotient is forced; the remainder (|A| re-signed) already equals A.
    assign w_hi_fixed = neg_if(w_rem_step, r_sign_a);
    assign w_lo_fixed = r_div_zero ? '1 : neg_if(w_quo_step, r_sign_a ^ r_sign_b);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        w_stall      = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Stall is raised in the capture cycle itself; gated by reset so
                // it reads zero while reset is held.
                if (w_req && !FlushE && !reset) begin
                    w_start = 1'b1;
                    w_stall = 1'b1;
`ifdef DIV_EARLY_OUT_EN
                    w_state_next = w_zero_div ? ST_DONE : ST_BUSY;
`else
                    w_state_next = ST_BUSY;
`endif
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (FlushE) begin
                    w_state_next = ST_IDLE;
                end else if (r_count == LAST_COUNT) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_valid = 1'b1;
                if (FlushE || !StallIn) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: the datapath is fully reset because the result registers drive
    // outputs that must read zero after reset; the rest follows for simplicity.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_rem      <= ZEROWORD;
            r_quo      <= ZEROWORD;
            r_div      <= ZEROWORD;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= ZEROWORD;
            r_lo       <= ZEROWORD;
        end else if (w_start) begin
            r_count    <= '0;
            r_rem      <= ZEROWORD;
            r_quo      <= neg_if(SrcAE, w_is_signed & SrcAE[DATALENGTH-1]);
            r_div      <= neg_if(SrcBE, w_is_signed & SrcBE[DATALENGTH-1]);
            r_sign_a   <= w_is_signed & SrcAE[DATALENGTH-1];
            r_sign_b   <= w_is_signed & SrcBE[DATALENGTH-1];
            r_div_zero <= w_zero_div;
`ifdef DIV_EARLY_OUT_EN
            if (w_zero_div) begin
                r_hi <= SrcAE;
                r_lo <= '1;
            end
`endif
        end else if (r_state == ST_BUSY) begin
            r_rem   <= w_rem_step;
            r_quo   <= w_quo_step;
            r_count <= r_count + COUNT_W'(1);
            if (w_finish) begin
                r_hi <= w_hi_fixed;
                r_lo <= w_lo_fixed;
            end
        end
    end

    assign StallDivE = w_stall;
    assign DivValidE = w_valid;
    assign HiDivE    = r_hi;
    assign LoDivE    = r_lo;

endmodule
